param_calculator: RTL and testbench

//  Parameterised N-bit ALU/calculator for the board-level lab top. Operands Z and Y

---
 rtl/param_calculator.sv | 152 +++++++++++++++
 tb/tb_param_calculator.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/param_calculator.sv
// param_calculator: N-bit ten-op ALU with registered result and hex 7-seg views.
// Optional status flags port when PARAM_CALC_FLAGS_EN is defined.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   Z, Y            operands (Y doubles as shift amount)
//   mode            op select within bank
//   btn_change      bank select
//   segA/segB/segD  active-low {g,f,e,d,c,b,a} hex of Z, Y, aritm_out (bits [3:0])
//   aritm_out       registered result
//   flags           {N,Z,C,V}, registered with aritm_out (PARAM_CALC_FLAGS_EN only)
module param_calculator #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] Z,
  input  logic [N-1:0] Y,
  input  logic [1:0]   mode,
  input  logic [1:0]   btn_change,
  output logic [6:0]   segA,
  output logic [6:0]   segB,
  output logic [6:0]   segD,
`ifdef PARAM_CALC_FLAGS_EN
  output logic [3:0]   flags,
`endif
  output logic [N-1:0] aritm_out
);

  localparam logic [3:0] OP_ADD = 4'b1100;
  localparam logic [3:0] OP_SUB = 4'b1101;
  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_DIV = 4'b1111;
  localparam logic [3:0] OP_MOD = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1011;
  localparam logic [3:0] OP_SHL = 4'b0010;
  localparam logic [3:0] OP_SHR = 4'b0001;

  localparam logic [N-1:0] N_W  = N[N-1:0];
  localparam logic [N-1:0] ONES = '1;
  localparam logic [N-1:0] ZERO = '0;
  localparam logic [6:0]   BLANK = 7'b1111111;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = BLANK;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  logic [3:0]     op;
  logic [N:0]     sum;
  logic [N:0]     dif;
  logic [2*N-1:0] prod;
  logic           y_zero;
  logic           sh_big;
  logic [N-1:0]   res;
  logic           cf;
  logic           vf;

  assign op     = {btn_change, mode};
  assign sum    = {1'b0, Z} + {1'b0, Y};
  // dif[N] is the borrow out of Z-Y
  assign dif    = {1'b0, Z} - {1'b0, Y};
  assign prod   = {{N{1'b0}}, Z} * {{N{1'b0}}, Y};
  assign y_zero = (Y == ZERO);
  assign sh_big = (Y >= N_W);

  always_comb begin
    res = ZERO;
    cf  = 1'b0;
    vf  = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        res = sum[N-1:0];
        cf  = sum[N];
        vf  = (Z[N-1] == Y[N-1]) && (sum[N-1] != Z[N-1]);
      end
      (op == OP_SUB): begin
        res = dif[N-1:0];
        cf  = dif[N];
        vf  = (Z[N-1] != Y[N-1]) && (dif[N-1] != Z[N-1]);
      end
      (op == OP_MUL): begin
        res = prod[N-1:0];
        cf  = |prod[2*N-1:N];
      end
      (op == OP_DIV): begin
        res = y_zero ? ONES : Z / Y;
        cf  = y_zero;
      end
      (op == OP_MOD): begin
        res = y_zero ? Z : Z % Y;
        cf  = y_zero;
      end
      (op == OP_AND): res = Z & Y;
      (op == OP_OR):  res = Z | Y;
      (op == OP_XOR): res = Z ^ Y;
      (op == OP_SHL): res = sh_big ? ZERO : Z << Y;
      (op == OP_SHR): res = sh_big ? ZERO : Z >> Y;
      default: res = ZERO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aritm_out <= ZERO;
      segA      <= BLANK;
      segB      <= BLANK;
      segD      <= BLANK;
    end else begin
      aritm_out <= res;
      segA      <= hex7(Z[3:0]);
      segB      <= hex7(Y[3:0]);
      segD      <= hex7(res[3:0]);
    end
  end

`ifdef PARAM_CALC_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else begin
      flags <= {res[N-1], (res == ZERO), cf, vf};
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^{cf, vf};
`endif

endmodule

// File: tb/tb_param_calculator.sv
// tb_param_calculator: directed checks of param_calculator (N=4).
// Hand-computed results, seg codes and (optionally) flags.
module tb_param_calculator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] Z = 4'd0;
  logic [3:0] Y = 4'd0;
  logic [1:0] mode = 2'b00;
  logic [1:0] btn_change = 2'b00;
  logic [6:0] segA, segB, segD;
  logic [3:0] aritm_out;
`ifdef PARAM_CALC_FLAGS_EN
  logic [3:0] flags;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  localparam logic [6:0] BLK = 7'b1111111;

  param_calculator #(.N(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Z(Z),
    .Y(Y),
    .mode(mode),
    .btn_change(btn_change),
    .segA(segA),
    .segB(segB),
    .segD(segD),
`ifdef PARAM_CALC_FLAGS_EN
    .flags(flags),
`endif
    .aritm_out(aritm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] z, input logic [3:0] y,
                       input logic [1:0] b, input logic [1:0] m);
    Z = z;
    Y = y;
    btn_change = b;
    mode = m;
  endtask

  task automatic step(input logic [3:0] z, input logic [3:0] y,
                      input logic [1:0] b, input logic [1:0] m);
    drive(z, y, b, m);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(4'd5, 4'd3, 2'b11, 2'b00);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_out", {4'h0, aritm_out}, 8'h00);
    chk("rst_async_segD", {1'b0, segD}, {1'b0, BLK});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_out", {4'h0, aritm_out}, 8'h00);
    chk("rst_hold_segA", {1'b0, segA}, {1'b0, BLK});
    chk("rst_hold_segB", {1'b0, segB}, {1'b0, BLK});
    chk("rst_hold_segD", {1'b0, segD}, {1'b0, BLK});
`ifdef PARAM_CALC_FLAGS_EN
    chk("rst_flags", {4'h0, flags}, 8'h00);
`endif
    rst_n = 1'b1;
    #2;
    chk("rel_before_edge", {4'h0, aritm_out}, 8'h00);
    @(posedge clk);
    #1;
    chk("add_5_3", {4'h0, aritm_out}, 8'h08);
    chk("add_5_3_segD", {1'b0, segD}, {1'b0, 7'b0000000});
    chk("add_5_3_segA", {1'b0, segA}, {1'b0, 7'b0010010});
    chk("add_5_3_segB", {1'b0, segB}, {1'b0, 7'b0110000});

    step(4'd8, 4'd8, 2'b11, 2'b00);
    chk("add_wrap", {4'h0, aritm_out}, 8'h00);
    chk("add_wrap_segD", {1'b0, segD}, {1'b0, 7'b1000000});
`ifdef PARAM_CALC_FLAGS_EN
    chk("add_wrap_flags", {4'h0, flags}, 8'b0111);
`endif

    step(4'd1, 4'd2, 2'b11, 2'b01);
    chk("sub_wrap", {4'h0, aritm_out}, 8'h0F);
    chk("sub_wrap_segD", {1'b0, segD}, {1'b0, 7'b0001110});
`ifdef PARAM_CALC_FLAGS_EN
    chk("sub_wrap_flags", {4'h0, flags}, 8'b1010);
`endif

    step(4'd5, 4'd3, 2'b11, 2'b10);
    chk("mul_5_3", {4'h0, aritm_out}, 8'h0F);
    step(4'd8, 4'd8, 2'b11, 2'b10);
    chk("mul_8_8", {4'h0, aritm_out}, 8'h00);
    step(4'd5, 4'd3, 2'b11, 2'b11);
    chk("div_5_3", {4'h0, aritm_out}, 8'h01);
    step(4'd5, 4'd3, 2'b10, 2'b00);
    chk("mod_5_3", {4'h0, aritm_out}, 8'h02);
    step(4'd1, 4'd0, 2'b11, 2'b11);
    chk("div_by0", {4'h0, aritm_out}, 8'h0F);
    step(4'd1, 4'd0, 2'b10, 2'b00);
    chk("mod_by0", {4'h0, aritm_out}, 8'h01);

    step(4'd5, 4'd3, 2'b10, 2'b01);
    chk("and_5_3", {4'h0, aritm_out}, 8'h01);
    step(4'd5, 4'd3, 2'b10, 2'b10);
    chk("or_5_3", {4'h0, aritm_out}, 8'h07);
    step(4'd5, 4'd3, 2'b10, 2'b11);
    chk("xor_5_3", {4'h0, aritm_out}, 8'h06);
    step(4'd8, 4'd8, 2'b10, 2'b11);
    chk("xor_8_8", {4'h0, aritm_out}, 8'h00);
    step(4'd1, 4'd0, 2'b10, 2'b01);
    chk("and_1_0", {4'h0, aritm_out}, 8'h00);

    step(4'd5, 4'd3, 2'b00, 2'b10);
    chk("shl_5_3", {4'h0, aritm_out}, 8'h08);
    step(4'd9, 4'd2, 2'b00, 2'b10);
    chk("shl_9_2", {4'h0, aritm_out}, 8'h04);
    step(4'd5, 4'd3, 2'b00, 2'b01);
    chk("shr_5_3", {4'h0, aritm_out}, 8'h00);
    step(4'd12, 4'd3, 2'b00, 2'b01);
    chk("shr_12_3", {4'h0, aritm_out}, 8'h01);
    step(4'd12, 4'd4, 2'b00, 2'b01);
    chk("shr_y_eq_n", {4'h0, aritm_out}, 8'h00);
    step(4'd8, 4'd8, 2'b00, 2'b10);
    chk("shl_8_8", {4'h0, aritm_out}, 8'h00);

    step(4'd7, 4'd6, 2'b11, 2'b00);
    chk("add_7_6", {4'h0, aritm_out}, 8'h0D);
    chk("add_7_6_segD", {1'b0, segD}, {1'b0, 7'b0100001});
    drive(4'd7, 4'd6, 2'b01, 2'b10);
    #2;
    chk("unused_no_early", {4'h0, aritm_out}, 8'h0D);
    @(posedge clk);
    #1;
    chk("unused_01_10", {4'h0, aritm_out}, 8'h00);
    step(4'd7, 4'd6, 2'b11, 2'b00);
    chk("add_again", {4'h0, aritm_out}, 8'h0D);
    step(4'd7, 4'd6, 2'b00, 2'b00);
    chk("unused_00_00", {4'h0, aritm_out}, 8'h00);
    step(4'd7, 4'd6, 2'b11, 2'b00);
    step(4'd7, 4'd6, 2'b00, 2'b11);
    chk("unused_00_11", {4'h0, aritm_out}, 8'h00);

    step(4'd10, 4'd1, 2'b11, 2'b00);
    chk("add_10_1", {4'h0, aritm_out}, 8'h0B);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out", {4'h0, aritm_out}, 8'h00);
    chk("midrst_segD", {1'b0, segD}, {1'b0, BLK});
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_load", {4'h0, aritm_out}, 8'h0B);
    chk("post_rst_segD", {1'b0, segD}, {1'b0, 7'b0000011});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
